// File: rtl/video_modulator_chroma_pkg.sv
// rtl/video_modulator_chroma_pkg.sv - shared constants and quarter-wave sine table for the chroma path
package video_modulator_chroma_pkg;

    localparam int PHASE_W = 9;
    localparam int SIN_W   = 8;

    localparam logic [23:0]        NTSC_PHASE_INC = 24'd2402193;
    localparam logic [7:0]         BURST_AMP_DEF  = 8'd40;
    localparam logic [PHASE_W-1:0] QUARTER        = 9'd128;

    // round(100 * sin(i * pi / 256)) for i = 0..128 (first quadrant, inclusive of 90 deg)
    localparam logic [7:0] SIN_QTAB [0:128] = '{
        8'd0,   8'd1,   8'd2,   8'd4,   8'd5,   8'd6,   8'd7,   8'd9,
        8'd10,  8'd11,  8'd12,  8'd13,  8'd15,  8'd16,  8'd17,  8'd18,
        8'd20,  8'd21,  8'd22,  8'd23,  8'd24,  8'd25,  8'd27,  8'd28,
        8'd29,  8'd30,  8'd31,  8'd33,  8'd34,  8'd35,  8'd36,  8'd37,
        8'd38,  8'd39,  8'd41,  8'd42,  8'd43,  8'd44,  8'd45,  8'd46,
        8'd47,  8'd48,  8'd49,  8'd50,  8'd51,  8'd52,  8'd53,  8'd55,
        8'd56,  8'd57,  8'd58,  8'd59,  8'd60,  8'd61,  8'd62,  8'd62,
        8'd63,  8'd64,  8'd65,  8'd66,  8'd67,  8'd68,  8'd69,  8'd70,
        8'd71,
        8'd72,  8'd72,  8'd73,  8'd74,  8'd75,  8'd76,  8'd77,  8'd77,
        8'd78,  8'd79,  8'd80,  8'd80,  8'd81,  8'd82,  8'd82,  8'd83,
        8'd84,  8'd84,  8'd85,  8'd86,  8'd86,  8'd87,  8'd88,  8'd88,
        8'd89,  8'd89,  8'd90,  8'd90,  8'd91,  8'd91,  8'd92,  8'd92,
        8'd93,  8'd93,  8'd94,  8'd94,  8'd95,  8'd95,  8'd95,  8'd96,
        8'd96,  8'd96,  8'd97,  8'd97,  8'd97,  8'd98,  8'd98,  8'd98,
        8'd98,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd99,  8'd100,
        8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100
    };

    // Quadrant folding: bit 7 mirrors the index, bit 8 negates the magnitude.
    function automatic logic signed [SIN_W-1:0] sin_lookup(input logic [PHASE_W-1:0] ph);
        logic [7:0]       qidx;
        logic [SIN_W-1:0] mag;
        qidx = ph[7] ? (8'd128 - {1'b0, ph[6:0]}) : {1'b0, ph[6:0]};
        mag  = SIN_QTAB[qidx];
        return ph[8] ? $signed(8'd0 - mag) : $signed(mag);
    endfunction

endpackage

// File: rtl/video_modulator_sinlut.sv
// rtl/video_modulator_sinlut.sv - registered 512-point signed sine lookup, no reset
module video_modulator_sinlut
    import video_modulator_chroma_pkg::*;
(
    input  logic                      clk,
    input  logic [PHASE_W-1:0]        phase,
    output logic signed [SIN_W-1:0]   value
);

    // Left unreset on purpose: the chroma valid pipeline masks anything stale.
    always_ff @(posedge clk) begin
        value <= sin_lookup(phase);
    end

endmodule

// File: rtl/video_modulator_chroma.sv
// rtl/video_modulator_chroma.sv - subcarrier NCO and quadrature chroma modulator with -U burst
module video_modulator_chroma
    import video_modulator_chroma_pkg::*;
#(
    parameter int               ACC_W     = 24,
    parameter logic [ACC_W-1:0] PHASE_INC = ACC_W'(NTSC_PHASE_INC),
    parameter logic [7:0]       BURST_AMP = BURST_AMP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chroma_en,
    input  logic              burst_en,
    input  logic              active,
    input  logic signed [7:0] u_in,
    input  logic signed [7:0] v_in,
    output logic signed [7:0] chroma_out,
    output logic              chroma_valid
);

    logic [ACC_W-1:0]         acc;
    logic [PHASE_W-1:0]       ph_sin;
    logic [PHASE_W-1:0]       ph_cos;
    logic signed [SIN_W-1:0]  sin_v;
    logic signed [SIN_W-1:0]  cos_v;

    logic signed [7:0]        u_sel;
    logic signed [7:0]        v_sel;
    logic signed [7:0]        u1;
    logic signed [7:0]        v1;
    logic                     val1;
    logic                     act1;
    logic signed [15:0]       p_u;
    logic signed [15:0]       p_v;
    logic                     val2;
    logic                     act2;
    logic signed [16:0]       sum;
    logic signed [9:0]        shifted;
    logic signed [7:0]        sat;

    assign ph_sin = acc[ACC_W-1 -: PHASE_W];
    assign ph_cos = ph_sin + QUARTER;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc + PHASE_INC;
        end
    end

    video_modulator_sinlut u_sin (
        .clk   (clk),
        .phase (ph_sin),
        .value (sin_v)
    );

    video_modulator_sinlut u_cos (
        .clk   (clk),
        .phase (ph_cos),
        .value (cos_v)
    );

    // Burst sits on the -U axis and overrides active video.
    always_comb begin
        u_sel = '0;
        v_sel = '0;
        if (chroma_en) begin
            if (burst_en) begin
                u_sel = $signed(8'd0 - BURST_AMP);
            end else if (active) begin
                u_sel = u_in;
                v_sel = v_in;
            end
        end
    end

    assign sum     = {p_u[15], p_u} + {p_v[15], p_v};
    assign shifted = sum[16:7];

    always_comb begin
        sat = shifted[7:0];
        if (shifted > 10'sd127) begin
            sat = 8'sd127;
        end else if (shifted < -10'sd128) begin
            sat = -8'sd128;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u1           <= '0;
            v1           <= '0;
            val1         <= 1'b0;
            act1         <= 1'b0;
            p_u          <= '0;
            p_v          <= '0;
            val2         <= 1'b0;
            act2         <= 1'b0;
            chroma_out   <= '0;
            chroma_valid <= 1'b0;
        end else begin
            u1           <= u_sel;
            v1           <= v_sel;
            val1         <= chroma_en & (burst_en | active);
            act1         <= burst_en | active;
            p_u          <= u1 * sin_v;
            p_v          <= v1 * cos_v;
            val2         <= val1;
            act2         <= act1;
            chroma_out   <= val2 ? sat : 8'sd0;
            chroma_valid <= val2 | act2;
        end
    end

endmodule

// File: tb/tb_video_modulator_chroma.sv
// tb/tb_video_modulator_chroma.sv - directed self-checking bench for video_modulator_chroma
module tb_video_modulator_chroma;

    logic              clk;
    logic              rst;
    logic              chroma_en;
    logic              burst_en;
    logic              active;
    logic signed [7:0] u_in;
    logic signed [7:0] v_in;
    logic signed [7:0] out_d, out_q, out_e;
    logic              vld_d, vld_q, vld_e;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    video_modulator_chroma dut (
        .clk(clk), .rst(rst), .chroma_en(chroma_en), .burst_en(burst_en), .active(active),
        .u_in(u_in), .v_in(v_in), .chroma_out(out_d), .chroma_valid(vld_d)
    );

    // Phase steps of 128: 0, 128, 256, 384
    video_modulator_chroma #(.PHASE_INC(24'd4194304)) dut_q (
        .clk(clk), .rst(rst), .chroma_en(chroma_en), .burst_en(burst_en), .active(active),
        .u_in(u_in), .v_in(v_in), .chroma_out(out_q), .chroma_valid(vld_q)
    );

    // Phase steps of 64: 0, 64, 128, ...
    video_modulator_chroma #(.PHASE_INC(24'd2097152)) dut_e (
        .clk(clk), .rst(rst), .chroma_en(chroma_en), .burst_en(burst_en), .active(active),
        .u_in(u_in), .v_in(v_in), .chroma_out(out_e), .chroma_valid(vld_e)
    );

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        chroma_en = 1'b1; burst_en = 1'b0; active = 1'b1; u_in = 8'sd50; v_in = 8'sd50;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_d !== 8'sd0 || vld_d !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got out=%0d valid=%0b, want out=0 valid=0", out_d, vld_d);
        end
        checks++;
        if (dut.acc !== 24'd0) begin
            errors++;
            $display("FAIL reset_acc: got %0d, want 0", dut.acc);
        end
        rst = 1'b0;
        checks++;
        if (dut.ph_sin !== 9'd0) begin
            errors++;
            $display("FAIL reset_first_phase: got %0d, want 0", dut.ph_sin);
        end
    endtask

    task automatic test_nco_wrap();
        chroma_en = 1'b0; burst_en = 1'b0; active = 1'b0; u_in = 8'sd0; v_in = 8'sd0;
        apply_reset();
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (dut.acc !== 24'd38135) begin
            errors++;
            $display("FAIL nco_wrap: got acc=%0d, want 38135", dut.acc);
        end
    endtask

    task automatic test_quadrature();
        logic signed [7:0] exp_q [4] = '{8'sd0, 8'sd50, 8'sd0, -8'sd50};
        chroma_en = 1'b1; burst_en = 1'b0; active = 1'b1; u_in = 8'sd64; v_in = 8'sd0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                checks++;
                if (out_q !== exp_q[i-2] || vld_q !== 1'b1) begin
                    errors++;
                    $display("FAIL quadrature[%0d]: got out=%0d valid=%0b, want out=%0d valid=1",
                             i - 2, out_q, vld_q, exp_q[i-2]);
                end
            end
        end
    endtask

    task automatic test_burst();
        logic signed [7:0] exp_b [4] = '{8'sd0, -8'sd32, 8'sd0, 8'sd31};
        chroma_en = 1'b1; burst_en = 1'b1; active = 1'b1; u_in = 8'sd64; v_in = 8'sd0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                checks++;
                if (out_q !== exp_b[i-2] || vld_q !== 1'b1) begin
                    errors++;
                    $display("FAIL burst[%0d]: got out=%0d valid=%0b, want out=%0d valid=1",
                             i - 2, out_q, vld_q, exp_b[i-2]);
                end
            end
        end
        burst_en = 1'b0;
    endtask

    task automatic test_saturation();
        logic signed [7:0] uv  [2] = '{8'sd127, -8'sd128};
        logic signed [7:0] ph0 [2] = '{8'sd99, -8'sd100};
        logic signed [7:0] ph64[2] = '{8'sd127, -8'sd128};
        for (int t = 0; t < 2; t++) begin
            chroma_en = 1'b1; burst_en = 1'b0; active = 1'b1; u_in = uv[t]; v_in = uv[t];
            apply_reset();
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (out_e !== ph0[t]) begin
                errors++;
                $display("FAIL sat_phase0[%0d]: got %0d, want %0d", t, out_e, ph0[t]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_e !== ph64[t]) begin
                errors++;
                $display("FAIL sat_phase64[%0d]: got %0d, want %0d", t, out_e, ph64[t]);
            end
        end
    endtask

    task automatic test_mono_and_midreset();
        chroma_en = 1'b0; burst_en = 1'b0; active = 1'b1; u_in = 8'sd100; v_in = 8'sd100;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                checks++;
                if (out_d !== 8'sd0 || vld_d !== 1'b1) begin
                    errors++;
                    $display("FAIL mono[%0d]: got out=%0d valid=%0b, want out=0 valid=1",
                             i, out_d, vld_d);
                end
            end
        end
        chroma_en = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_d !== 8'sd0 || vld_d !== 1'b0) begin
                errors++;
                $display("FAIL midreset_flush[%0d]: got out=%0d valid=%0b, want out=0 valid=0",
                         i, out_d, vld_d);
            end
            @(posedge clk);
            #1;
        end
        // Phase 0 sample: 100*0 + 100*100 = 10000, >>7 = 78
        checks++;
        if (out_d !== 8'sd78 || vld_d !== 1'b1) begin
            errors++;
            $display("FAIL midreset_resume: got out=%0d valid=%0b, want out=78 valid=1", out_d, vld_d);
        end
        active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_d !== 8'sd0 || vld_d !== 1'b0) begin
            errors++;
            $display("FAIL idle_blank: got out=%0d valid=%0b, want out=0 valid=0", out_d, vld_d);
        end
    endtask

    initial begin
        rst = 1'b1; chroma_en = 1'b0; burst_en = 1'b0; active = 1'b0;
        u_in = 8'sd0; v_in = 8'sd0;
        test_reset();
        test_nco_wrap();
        test_quadrature();
        test_burst();
        test_saturation();
        test_mono_and_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
